// File: rtl/bus_rr_arbiter4_if.sv
// Request/grant bundle between the four bus clients and the arbiter.
// The arbiter takes the master modport, the bus side the slave one.
interface bus_rr_arbiter4_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       busy;
  logic       timeout_err;

  modport master (
    input  req,
    input  done,
    output gnt,
    output gnt_id,
    output gnt_valid,
    output busy,
    output timeout_err
  );

  modport slave (
    output req,
    output done,
    input  gnt,
    input  gnt_id,
    input  gnt_valid,
    input  busy,
    input  timeout_err
  );
endinterface

// File: rtl/bus_rr_arbiter4.sv
// Four-way round-robin arbiter for the shared outbound bus port,
// holding each grant until done or until the watchdog expires.
module bus_rr_arbiter4 #(
  parameter bit TIMEOUT_EN = 1'b1,
  parameter int TIMEOUT_W  = 8
) (
  input logic                clk,
  input logic                resetn,
  bus_rr_arbiter4_if.master  bus
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t               state;
  logic [1:0]           ptr;
  logic [TIMEOUT_W-1:0] cnt;
  logic [3:0]           gnt_q;
  logic [1:0]           id_q;
  logic                 err_q;

  logic [1:0] p1;
  logic [1:0] p2;
  logic [1:0] p3;
  logic [3:0] rot;
  logic [1:0] off;
  logic [1:0] win;
  logic       any;
  logic       lim;
  logic       rel;

  assign p1 = ptr + 2'd1;
  assign p2 = ptr + 2'd2;
  assign p3 = ptr + 2'd3;

  // rot[k] is the requester k+1 places after the last owner
  assign rot = {bus.req[ptr], bus.req[p3], bus.req[p2], bus.req[p1]};
  assign any = |bus.req;

  always_comb begin
    off = 2'd3;
    priority case (1'b1)
      rot[0]:  off = 2'd0;
      rot[1]:  off = 2'd1;
      rot[2]:  off = 2'd2;
      default: off = 2'd3;
    endcase
  end

  assign win = p1 + off;
  assign lim = TIMEOUT_EN && (cnt == '1);
  assign rel = bus.done || lim;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      ptr   <= 2'd3;
      cnt   <= '0;
      gnt_q <= 4'd0;
      id_q  <= 2'd0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (state == IDLE || rel) begin
        // done wins over a coinciding watchdog expiry
        err_q <= (state == GRANT) && !bus.done && lim;
        if (any) begin
          state <= GRANT;
          ptr   <= win;
          cnt   <= '0;
          gnt_q <= 4'b0001 << win;
          id_q  <= win;
        end else begin
          state <= IDLE;
          gnt_q <= 4'd0;
          id_q  <= 2'd0;
        end
      end else if (cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.gnt_id      = id_q;
  assign bus.gnt_valid   = (state == GRANT);
  assign bus.busy        = (state == GRANT);
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_bus_rr_arbiter4.sv
// Bench for bus_rr_arbiter4: directed scenarios with literal
// expectations plus random traffic against an ownership model.
module tb_bus_rr_arbiter4;

  localparam int TW  = 3;
  localparam bit TEN = 1'b1;
  localparam int LIM = 1 << TW;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  int errors = 0;
  int checks = 0;

  bus_rr_arbiter4_if bus ();

  bus_rr_arbiter4 #(
    .TIMEOUT_EN(TEN),
    .TIMEOUT_W (TW)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endfunction

  // model: who owns the bus, who owned it last, grant age
  int m_own  = -1;
  int m_last = 3;
  int m_age  = 0;
  bit m_to   = 1'b0;

  task automatic model_step();
    int w;
    bit rel;
    m_to = 1'b0;
    if (!resetn) begin
      m_own  = -1;
      m_last = 3;
      m_age  = 0;
      return;
    end
    rel = (m_own < 0) || bus.done || (TEN && m_age == LIM);
    if (m_own >= 0 && !bus.done && TEN && m_age == LIM)
      m_to = 1'b1;
    w = -1;
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (m_last + k) % 4;
      if (w < 0 && bus.req[c]) w = c;
    end
    if (rel) begin
      if (w >= 0) begin
        m_own  = w;
        m_last = w;
        m_age  = 1;
      end else begin
        m_own = -1;
      end
    end else begin
      m_age++;
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("m_gnt", bus.gnt,
        (m_own < 0) ? 32'd0 : (32'd1 << m_own));
    chk("m_id", bus.gnt_id,
        (m_own < 0) ? 32'd0 : m_own);
    chk("m_valid", bus.gnt_valid, (m_own >= 0) ? 32'd1 : 32'd0);
    chk("m_busy", bus.busy, (m_own >= 0) ? 32'd1 : 32'd0);
    chk("m_to", bus.timeout_err, m_to ? 32'd1 : 32'd0);
  end

  task automatic drive(input logic [3:0] r, input logic d);
    bus.req  = r;
    bus.done = d;
    @(negedge clk);
  endtask

  initial begin
    bus.req  = 4'd0;
    bus.done = 1'b0;
    resetn   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_valid", bus.gnt_valid, 0);
    chk("rst_err", bus.timeout_err, 0);
    resetn = 1'b1;

    // single request, hold, release
    drive(4'b0001, 1'b0);
    chk("t1_gnt", bus.gnt, 4'b0001);
    chk("t1_id", bus.gnt_id, 0);
    drive(4'b0001, 1'b0);
    drive(4'b0001, 1'b0);
    chk("t1_hold", bus.gnt, 4'b0001);
    drive(4'b0000, 1'b1);
    chk("t1_rel", bus.gnt, 0);
    chk("t1_busy", bus.busy, 0);

    // all requesting, done every second grant cycle
    resetn = 1'b0;
    drive(4'b0000, 1'b0);
    resetn = 1'b1;
    drive(4'b1111, 1'b0);
    for (int g = 0; g < 6; g++) begin
      chk("t2_id_a", bus.gnt_id, g % 4);
      chk("t2_valid_a", bus.gnt_valid, 1);
      drive(4'b1111, 1'b0);
      chk("t2_id_b", bus.gnt_id, g % 4);
      drive(4'b1111, 1'b1);
    end

    // owner 2 now; rotation past the served requester
    chk("t3_own2", bus.gnt_id, 2);
    drive(4'b1011, 1'b1);
    chk("t3_next3", bus.gnt_id, 3);
    drive(4'b0011, 1'b1);
    chk("t3_next0", bus.gnt_id, 0);
    drive(4'b0011, 1'b1);
    chk("t3_next1", bus.gnt_id, 1);
    drive(4'b0000, 1'b1);
    chk("t3_idle", bus.gnt, 0);

    // watchdog expiry after LIM grant cycles
    drive(4'b0010, 1'b0);
    chk("t4_gnt", bus.gnt, 4'b0010);
    for (int i = 1; i < LIM; i++) begin
      drive(4'b0000, 1'b0);
      chk("t4_held", bus.gnt, 4'b0010);
      chk("t4_noerr", bus.timeout_err, 0);
    end
    drive(4'b0000, 1'b0);
    chk("t4_rel", bus.gnt, 0);
    chk("t4_err", bus.timeout_err, 1);
    drive(4'b0000, 1'b0);
    chk("t4_err_pulse", bus.timeout_err, 0);

    // done on the last cycle beats the watchdog
    drive(4'b0010, 1'b0);
    for (int i = 1; i < LIM; i++) drive(4'b0000, 1'b0);
    chk("t4b_held", bus.gnt, 4'b0010);
    drive(4'b0000, 1'b1);
    chk("t4b_rel", bus.gnt, 0);
    chk("t4b_noerr", bus.timeout_err, 0);

    // reset in the middle of a grant
    drive(4'b1000, 1'b0);
    chk("t5_own3", bus.gnt, 4'b1000);
    resetn = 1'b0;
    drive(4'b1111, 1'b0);
    chk("t5_gnt0", bus.gnt, 0);
    chk("t5_id0", bus.gnt_id, 0);
    chk("t5_busy0", bus.busy, 0);
    resetn = 1'b1;
    drive(4'b1111, 1'b0);
    chk("t5_first", bus.gnt, 4'b0001);
    drive(4'b0000, 1'b1);

    // done in idle, and owner dropping req early
    drive(4'b0000, 1'b1);
    chk("t6_idle_done", bus.gnt, 0);
    drive(4'b0100, 1'b0);
    chk("t6_gnt", bus.gnt, 4'b0100);
    drive(4'b0000, 1'b0);
    drive(4'b0000, 1'b0);
    chk("t6_hold", bus.gnt, 4'b0100);
    drive(4'b0000, 1'b1);
    chk("t6_rel", bus.gnt, 0);

    // random traffic, model checks every cycle
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] r;
      logic d;
      r      = 4'($urandom_range(0, 15));
      if (i < 900) d = ($urandom_range(0, 2) == 0);
      else         d = ($urandom_range(0, 11) == 0);
      resetn = ($urandom_range(0, 99) != 0);
      drive(r, d);
    end
    resetn = 1'b1;
    drive(4'b0000, 1'b1);
    drive(4'b0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
